// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared constants for the UART receive drain path: drain FSM
//               state encoding, FIFO record field positions, and the
//               FCR trigger-level decode.
//               Record layout: {data[7:0], break, parity_err, framing_err}.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // FIFO record field positions
    localparam int DATA_MSB = 10;
    localparam int DATA_LSB = 3;
    localparam int BRK      = 2;
    localparam int PE       = 1;
    localparam int FE       = 0;

    // Receive trigger levels selected by fcr_trig_i = 00/01/10/11
    localparam int TRIG_LVL_1  = 1;
    localparam int TRIG_LVL_4  = 4;
    localparam int TRIG_LVL_8  = 8;
    localparam int TRIG_LVL_14 = 14;

    // Drain FSM state encoding
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD      = 3'd1;
    localparam logic [STATE_W-1:0] ST_PRESENT   = 3'd2;
    localparam logic [STATE_W-1:0] ST_SETTLE    = 3'd3;
    localparam logic [STATE_W-1:0] ST_FLUSH_POP = 3'd4;
    localparam logic [STATE_W-1:0] ST_FLUSH_SET = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE      = ST_IDLE,
        S_LOAD      = ST_LOAD,
        S_PRESENT   = ST_PRESENT,
        S_SETTLE    = ST_SETTLE,
        S_FLUSH_POP = ST_FLUSH_POP,
        S_FLUSH_SET = ST_FLUSH_SET
    } state_t;

    // FCR trigger field to occupancy threshold
    function automatic int trig_level(input logic [1:0] trig);
        int lvl;
        case (trig)
            2'b00:   lvl = TRIG_LVL_1;
            2'b01:   lvl = TRIG_LVL_4;
            2'b10:   lvl = TRIG_LVL_8;
            default: lvl = TRIG_LVL_14;
        endcase
        return lvl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_trig_decode.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_trig_decode
// Description : Decodes the FCR trigger field into an occupancy threshold and
//               registers the receive-data-available (rda) and character
//               timeout (ti) indications every cycle.
// Ports       : clk, wb_rst_ni      - clock, async active-low reset
//               fcr_trig_i          - trigger select (1/4/8/14 entries)
//               rf_count_i          - FIFO occupancy
//               counter_t_i         - receiver timeout counter (0 = expired)
//               trig_level_o        - decoded threshold (combinational)
//               rda_int_o, ti_int_o - registered indications
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_trig_decode
    import uart_rx_pkg::*;
#(
    parameter int FIFO_COUNTER_W = 5
) (
    input  logic                      clk,
    input  logic                      wb_rst_ni,
    input  logic [1:0]                fcr_trig_i,
    input  logic [FIFO_COUNTER_W-1:0] rf_count_i,
    input  logic [9:0]                counter_t_i,
    output logic [FIFO_COUNTER_W-1:0] trig_level_o,
    output logic                      rda_int_o,
    output logic                      ti_int_o
);

    logic r_rda;
    logic r_ti;

    always_comb begin
        trig_level_o = FIFO_COUNTER_W'(trig_level(fcr_trig_i));
    end

    // Both indications follow their condition with one cycle of delay and
    // are independent of the drain sequencing.
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_rda <= 1'b0;
            r_ti  <= 1'b0;
        end else begin
            r_rda <= (rf_count_i >= trig_level_o);
            r_ti  <= (counter_t_i == '0) && (rf_count_i != '0);
        end
    end

    assign rda_int_o = r_rda;
    assign ti_int_o  = r_ti;

endmodule
`default_nettype wire

// File: rtl/uart_rx_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_drain_ctrl
// Description : Drains the UART receive FIFO one record at a time and hands
//               each character to a valid/ready byte sink. Bursts start on
//               trigger level or character timeout and continue until the
//               FIFO is empty or enable_i drops. flush_i discards the held
//               character and empties the FIFO, popping every other cycle.
// Ports       : clk, wb_rst_ni            - clock, async active-low reset
//               enable_i, fcr_trig_i      - drain enable, trigger select
//               flush_i                   - flush pulse
//               rf_count_i, rf_data_i     - FIFO occupancy / head record
//               counter_t_i               - receiver timeout counter
//               rf_pop_o                  - FIFO pop pulse
//               m_valid_o, m_ready_i,
//               m_data_o, m_status_o      - character output handshake
//               rda_int_o, ti_int_o       - trigger / timeout indications
//               err_cnt_o                 - saturating errored-record count
//               busy_o                    - FSM not idle
// Options     : UART_RX_DRAIN_ERR_DROP_EN - records with any status bit set
//               are popped and counted but never presented.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_drain_ctrl
    import uart_rx_pkg::*;
#(
    parameter int FIFO_COUNTER_W = 5,
    parameter int REC_WIDTH      = 11,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      wb_rst_ni,
    input  logic                      enable_i,
    input  logic [1:0]                fcr_trig_i,
    input  logic                      flush_i,
    input  logic [FIFO_COUNTER_W-1:0] rf_count_i,
    input  logic [REC_WIDTH-1:0]      rf_data_i,
    input  logic [9:0]                counter_t_i,
    output logic                      rf_pop_o,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic [7:0]                m_data_o,
    output logic [2:0]                m_status_o,
    output logic                      rda_int_o,
    output logic                      ti_int_o,
    output logic [ERR_CNT_W-1:0]      err_cnt_o,
    output logic                      busy_o
);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [7:0]                r_data;
    logic [2:0]                r_status;
    logic [ERR_CNT_W-1:0]      r_err_cnt;
    logic [FIFO_COUNTER_W-1:0] w_trig_level;
    logic                      w_cnt_nz;
    logic                      w_at_trig;
    logic                      w_timeout;
    logic                      w_rec_err;

    assign w_cnt_nz  = (rf_count_i != '0);
    assign w_at_trig = (rf_count_i >= w_trig_level);
    assign w_timeout = (counter_t_i == '0);
    assign w_rec_err = |rf_data_i[BRK:FE];

    uart_rx_trig_decode #(
        .FIFO_COUNTER_W (FIFO_COUNTER_W)
    ) u_trig_decode (
        .clk          (clk),
        .wb_rst_ni    (wb_rst_ni),
        .fcr_trig_i   (fcr_trig_i),
        .rf_count_i   (rf_count_i),
        .counter_t_i  (counter_t_i),
        .trig_level_o (w_trig_level),
        .rda_int_o    (rda_int_o),
        .ti_int_o     (ti_int_o)
    );

    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        rf_pop_o     = 1'b0;
        m_valid_o    = 1'b0;
        busy_o       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (flush_i) begin
                    if (w_cnt_nz) begin
                        w_state_next = S_FLUSH_POP;
                    end
                end else if (enable_i && w_cnt_nz && (w_at_trig || w_timeout)) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                // Count gate is defensive: LOAD is only entered with data.
                rf_pop_o = w_cnt_nz;
`ifdef UART_RX_DRAIN_ERR_DROP_EN
                w_state_next = w_rec_err ? S_SETTLE : S_PRESENT;
`else
                w_state_next = S_PRESENT;
`endif
            end
            S_PRESENT: begin
                m_valid_o = 1'b1;
                // Flush wins over a same-cycle handshake: the held character
                // is treated as discarded.
                if (flush_i) begin
                    w_state_next = S_FLUSH_SET;
                end else if (m_ready_i) begin
                    w_state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Count has now absorbed the last pop; trigger is not
                // re-evaluated so a started burst runs to empty.
                if (flush_i) begin
                    w_state_next = S_FLUSH_SET;
                end else if (enable_i && w_cnt_nz) begin
                    w_state_next = S_LOAD;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_FLUSH_POP: begin
                rf_pop_o     = w_cnt_nz;
                w_state_next = S_FLUSH_SET;
            end
            S_FLUSH_SET: begin
                w_state_next = w_cnt_nz ? S_FLUSH_POP : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Character capture and error accounting happen on the popping edge.
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_data    <= '0;
            r_status  <= '0;
            r_err_cnt <= '0;
        end else begin
            if (r_state == S_LOAD) begin
                r_data   <= rf_data_i[DATA_MSB:DATA_LSB];
                r_status <= rf_data_i[BRK:FE];
            end
            if (rf_pop_o && w_rec_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign m_data_o   = r_data;
    assign m_status_o = r_status;
    assign err_cnt_o  = r_err_cnt;

endmodule
`default_nettype wire
